// File: rtl/iobus_pkg.sv
// Shared constants and helpers for PDP-6 IO-bus slave devices.
// Status word bits are numbered with bit 0 as the MSB, matching the bus.
package iobus_pkg;

    localparam int IOS_W    = 7;
    localparam int WORD_W   = 36;
    localparam int PI_W     = 7;
    localparam int PIA_W    = 3;
    localparam int PIA_LSB  = 35;
    localparam int DONE_BIT = 32;
    localparam int BUSY_BIT = 31;
    localparam int ERR_BIT  = 30;

    // Channel 0 means "no channel", so it never raises a request line.
    function automatic logic [1:PI_W] pi_onehot(input logic [0:PIA_W-1] pia);
        logic [1:PI_W] oh;
        oh = '0;
        for (int i = 1; i <= PI_W; i++) begin
            if (pia == 3'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/iob_dev_ctl.sv
// Device-select decode, CONO/DATAO register updates and CONI/DATAI read mux.
// Build option IOB_OVERRUN_ERR_EN: DATAO while busy is rejected and flags err.
module iob_dev_ctl
    import iobus_pkg::*;
#(
    parameter logic [0:IOS_W-1] DEVICE = 7'o104
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              iob_poweron_i,
    input  logic              iob_reset_i,
    input  logic              datao_clear_i,
    input  logic              datao_set_i,
    input  logic              cono_clear_i,
    input  logic              cono_set_i,
    input  logic              iob_fm_datai_i,
    input  logic              iob_fm_status_i,
    input  logic [3:9]        ios_i,
    input  logic [0:WORD_W-1] iob_write_i,
    input  logic              last_accept_i,
    output logic              rst_o,
    output logic              start_o,
    output logic              abort_o,
    output logic [0:WORD_W-1] buf_o,
    output logic [1:PI_W]     pi_req_o,
    output logic [0:WORD_W-1] iob_read_o
);

    logic              sel;
    logic              doClr, doSet, coClr, coSet;
    logic [0:PIA_W-1]  pia_q, pia_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [0:WORD_W-1] bufWord_q, bufWord_d;
    logic              start;
    logic              err;
    logic [0:WORD_W-1] status;
`ifdef IOB_OVERRUN_ERR_EN
    logic              err_q, err_d;
`endif

    assign rst_o = reset_i | iob_reset_i | ~iob_poweron_i;
    assign sel   = (ios_i == DEVICE);
    assign doClr = sel & datao_clear_i;
    assign doSet = sel & datao_set_i;
    assign coClr = sel & cono_clear_i;
    assign coSet = sel & cono_set_i;

`ifdef IOB_OVERRUN_ERR_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Later assignments override earlier ones, so the lowest-priority event
    // (a finished transfer) is applied first and CONO last; CONO set still
    // ORs on top of a same-cycle CONO clear.
    always_comb begin
        pia_d     = pia_q;
        done_d    = done_q;
        busy_d    = busy_q;
        bufWord_d = bufWord_q;
        start     = 1'b0;
`ifdef IOB_OVERRUN_ERR_EN
        err_d     = err_q;
`endif
        if (last_accept_i) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (doClr) begin
            bufWord_d = '0;
        end
        if (doSet) begin
`ifdef IOB_OVERRUN_ERR_EN
            if (busy_q && !last_accept_i) begin
                err_d = 1'b1;
            end else begin
                bufWord_d = bufWord_d | iob_write_i;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                start     = 1'b1;
            end
`else
            bufWord_d = bufWord_d | iob_write_i;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            start     = 1'b1;
`endif
        end
        if (coClr) begin
            pia_d  = '0;
            done_d = 1'b0;
            busy_d = 1'b0;
            start  = 1'b0;
`ifdef IOB_OVERRUN_ERR_EN
            err_d  = 1'b0;
`endif
        end
        if (coSet) begin
            pia_d  = pia_d | iob_write_i[PIA_LSB-PIA_W+1 +: PIA_W];
            done_d = done_d | iob_write_i[DONE_BIT];
            busy_d = busy_d | iob_write_i[BUSY_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_o) begin
            pia_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bufWord_q <= '0;
`ifdef IOB_OVERRUN_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            pia_q     <= pia_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            bufWord_q <= bufWord_d;
`ifdef IOB_OVERRUN_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        status                                = '0;
        status[PIA_LSB-PIA_W+1 +: PIA_W]      = pia_q;
        status[DONE_BIT]                      = done_q;
        status[BUSY_BIT]                      = busy_q;
        status[ERR_BIT]                       = err;
    end

    assign iob_read_o = (sel && iob_fm_status_i) ? status :
                        (sel && iob_fm_datai_i)  ? bufWord_q : '0;
    assign pi_req_o   = (done_q || err) ? pi_onehot(pia_q) : '0;
    assign start_o    = start;
    assign abort_o    = coClr;
    assign buf_o      = bufWord_q;

endmodule

// File: rtl/iob_char_out_dev.sv
// PDP-6 IO-bus character output device: serialises each DATAO word onto a valid/ready sink.
// Build option IOB_OVERRUN_ERR_EN selects reject-and-flag behaviour for DATAO while busy.
module iob_char_out_dev
    import iobus_pkg::*;
#(
    parameter logic [0:IOS_W-1] DEVICE = 7'o104,
    parameter int               CHARS  = 6,
    parameter int               CHAR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iob_poweron,
    input  logic              iob_reset,
    input  logic              datao_clear,
    input  logic              datao_set,
    input  logic              cono_clear,
    input  logic              cono_set,
    input  logic              iob_fm_datai,
    input  logic              iob_fm_status,
    input  logic [3:9]        ios,
    input  logic [0:35]       iob_write,
    output logic [1:7]        pi_req,
    output logic [0:35]       iob_read,
    output logic [0:CHAR_W-1] ch_data,
    output logic              ch_valid,
    input  logic              ch_ready
);

    localparam int         IDX_W    = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;

    logic              rst, start, abort;
    logic [0:35]       bufWord;
    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept, lastAccept;
    logic [0:CHAR_W-1] chData;

    iob_dev_ctl #(
        .DEVICE (DEVICE)
    ) u_ctl (
        .clk             (clk),
        .reset_i         (reset),
        .iob_poweron_i   (iob_poweron),
        .iob_reset_i     (iob_reset),
        .datao_clear_i   (datao_clear),
        .datao_set_i     (datao_set),
        .cono_clear_i    (cono_clear),
        .cono_set_i      (cono_set),
        .iob_fm_datai_i  (iob_fm_datai),
        .iob_fm_status_i (iob_fm_status),
        .ios_i           (ios),
        .iob_write_i     (iob_write),
        .last_accept_i   (lastAccept),
        .rst_o           (rst),
        .start_o         (start),
        .abort_o         (abort),
        .buf_o           (bufWord),
        .pi_req_o        (pi_req),
        .iob_read_o      (iob_read)
    );

    assign ch_valid   = (state_q == ST_SEND);
    assign accept     = ch_valid & ch_ready;
    assign lastAccept = accept && (idx_q == IDX_W'(CHARS - 1));

    // A fresh word restarts at the first character even mid-word; an abort beats both.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (accept) begin
            if (lastAccept) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        if (start) begin
            state_d = ST_SEND;
            idx_d   = '0;
        end
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        chData = '0;
        if (ch_valid) begin
            for (int i = 0; i < CHARS; i++) begin
                if (idx_q == IDX_W'(i)) chData = bufWord[i*CHAR_W +: CHAR_W];
            end
        end
    end

    assign ch_data = chData;

endmodule

// File: tb/tb_iob_char_out_dev.sv
// Self-checking bench for iob_char_out_dev: queue-based reference model plus directed vectors.
module tb_iob_char_out_dev;

   localparam logic [6:0] DEV = 7'o104;

   logic        clk = 1'b0;
   logic        reset, iob_poweron, iob_reset;
   logic        datao_clear, datao_set, cono_clear, cono_set;
   logic        iob_fm_datai, iob_fm_status;
   logic [3:9]  ios;
   logic [0:35] iob_write;
   logic [1:7]  pi_req;
   logic [0:35] iob_read;
   logic [0:5]  ch_data;
   logic        ch_valid;
   logic        ch_ready;

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 1'b0;

   logic [35:0] mBuf;
   int          mPia;
   bit          mDone, mBusy, mErr;
   int          mQ[$];
   int          rxLog[$];

   iob_char_out_dev dut (
      .clk           (clk),
      .reset         (reset),
      .iob_poweron   (iob_poweron),
      .iob_reset     (iob_reset),
      .datao_clear   (datao_clear),
      .datao_set     (datao_set),
      .cono_clear    (cono_clear),
      .cono_set      (cono_set),
      .iob_fm_datai  (iob_fm_datai),
      .iob_fm_status (iob_fm_status),
      .ios           (ios),
      .iob_write     (iob_write),
      .pi_req        (pi_req),
      .iob_read      (iob_read),
      .ch_data       (ch_data),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready)
   );

   always #5 clk = ~clk;

   // Single comparison point: every check and every failure is counted here.
   task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %o, expected %o", name, actual, expected);
      end
   endtask

   // Compares the characters the sink accepted against a hand-packed list, first character leftmost.
   task automatic checkRx(input string name, input int n, input logic [47:0] packedExp);
      logic [35:0] got;
      checkOutput({name, "_count"}, 36'(rxLog.size()), 36'(n));
      for (int k = 0; k < n; k++) begin
         got = (k < rxLog.size()) ? 36'(rxLog[k]) : 36'hfffffffff;
         checkOutput(name, got, 36'(packedExp[(n-1-k)*6 +: 6]));
      end
      rxLog.delete();
   endtask

   // Model: a word becomes a queue of characters, MSB character first.
   task automatic loadChars();
      mQ.delete();
      for (int i = 0; i < 6; i++) mQ.push_back(int'((mBuf >> (30 - 6*i)) & 36'h3f));
   endtask

   // Holds the current inputs across one rising edge and advances the model with them.
   task automatic applyStimulus();
      bit sel, last, overrun;
      @(posedge clk);
      sel  = (ios == DEV);
      last = 1'b0;
      if (reset || iob_reset || !iob_poweron) begin
         mBuf = '0; mPia = 0; mDone = 0; mBusy = 0; mErr = 0;
         mQ.delete();
      end else begin
         if (mQ.size() > 0 && ch_ready) begin
            void'(mQ.pop_front());
            if (mQ.size() == 0) begin
               last  = 1'b1;
               mBusy = 1'b0;
               mDone = 1'b1;
            end
         end
         if (sel && datao_clear) mBuf = '0;
         if (sel && datao_set) begin
`ifdef IOB_OVERRUN_ERR_EN
            overrun = mBusy && !last;
`else
            overrun = 1'b0;
`endif
            if (overrun) begin
               mErr = 1'b1;
            end else begin
               mBuf  = mBuf | iob_write;
               mBusy = 1'b1;
               mDone = 1'b0;
               loadChars();
            end
         end
         if (sel && cono_clear) begin
            mPia = 0; mDone = 0; mBusy = 0; mErr = 0;
            mQ.delete();
         end
         if (sel && cono_set) begin
            mPia  = mPia | int'(iob_write[33:35]);
            mDone = mDone | iob_write[32];
            mBusy = mBusy | iob_write[31];
         end
      end
      #1;
   endtask

   // Every cycle, away from the rising edge, the DUT must agree with the model.
   always @(negedge clk) begin
      logic [35:0] st, expRead;
      logic [6:0]  expPi;
      bit          sel;
      if (cmpEn) begin
         sel     = (ios == DEV);
         st      = 36'((int'(mErr) << 5) | (int'(mBusy) << 4) | (int'(mDone) << 3) | mPia);
         expRead = (sel && iob_fm_status) ? st : (sel && iob_fm_datai) ? mBuf : 36'd0;
         expPi   = ((mDone || mErr) && mPia != 0) ? 7'(1 << (7 - mPia)) : 7'd0;
         checkOutput("ch_valid", 36'(ch_valid), 36'(mQ.size() > 0));
         checkOutput("ch_data", 36'(ch_data), (mQ.size() > 0) ? 36'(mQ[0]) : 36'd0);
         checkOutput("pi_req", 36'(pi_req), 36'(expPi));
         checkOutput("iob_read", iob_read, expRead);
         if (ch_valid && ch_ready) rxLog.push_back(int'(ch_data));
      end
   end

   // Directed sequence: reset, CONO, DATAO, backpressure, wrong device, overrun, power loss.
   initial begin
      reset = 1'b1; iob_poweron = 1'b1; iob_reset = 1'b0;
      datao_clear = 1'b0; datao_set = 1'b0; cono_clear = 1'b0; cono_set = 1'b0;
      iob_fm_datai = 1'b0; iob_fm_status = 1'b0;
      ios = DEV; iob_write = '0; ch_ready = 1'b0;

      applyStimulus();
      reset = 1'b0;
      cmpEn = 1'b1;
      checkOutput("rst_pi", 36'(pi_req), 36'd0);
      checkOutput("rst_valid", 36'(ch_valid), 36'd0);
      iob_fm_status = 1'b1;
      #1;
      checkOutput("rst_coni", iob_read, 36'd0);

      cono_clear = 1'b1; cono_set = 1'b1; iob_write = 36'o000000000023;
      applyStimulus();
      cono_clear = 1'b0; cono_set = 1'b0;
      #1;
      checkOutput("coni_23", iob_read, 36'o000000000023);

      cono_clear = 1'b1; cono_set = 1'b1; iob_write = 36'o000000000013;
      applyStimulus();
      cono_clear = 1'b0; cono_set = 1'b0;
      #1;
      checkOutput("pi_pia3", 36'(pi_req), 36'(7'b0010000));
      checkOutput("coni_13", iob_read, 36'o000000000013);

      ch_ready = 1'b1;
      datao_clear = 1'b1; datao_set = 1'b1; iob_write = 36'o010203040506;
      applyStimulus();
      datao_clear = 1'b0; datao_set = 1'b0; iob_write = '0;
      repeat (5) applyStimulus();
      checkOutput("busy_mid", iob_read, 36'o000000000023);
      applyStimulus();
      checkOutput("done_after", iob_read, 36'o000000000013);
      checkOutput("pi_after", 36'(pi_req), 36'(7'b0010000));
      checkRx("datao_chars", 6, 48'({6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06}));

      datao_clear = 1'b1; datao_set = 1'b1; iob_write = 36'o111213141516;
      applyStimulus();
      datao_clear = 1'b0; datao_set = 1'b0; iob_write = '0;
      repeat (2) applyStimulus();
      ch_ready = 1'b0;
      repeat (5) begin
         applyStimulus();
         checkOutput("bp_hold", 36'(ch_data), 36'o13);
         checkOutput("bp_busy", 36'(iob_read[31]), 36'd1);
      end
      ch_ready = 1'b1;
      repeat (5) applyStimulus();
      checkRx("bp_chars", 6, 48'({6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o16}));

      ios = DEV ^ 7'd1;
      datao_clear = 1'b1; datao_set = 1'b1; cono_clear = 1'b1; cono_set = 1'b1;
      iob_write = '1; iob_fm_datai = 1'b1;
      #1;
      checkOutput("wd_read", iob_read, 36'd0);
      applyStimulus();
      datao_clear = 1'b0; datao_set = 1'b0; cono_clear = 1'b0; cono_set = 1'b0;
      iob_write = '0; iob_fm_datai = 1'b0; ios = DEV;
      #1;
      checkOutput("wd_status", iob_read, 36'o000000000013);
      iob_fm_status = 1'b0; iob_fm_datai = 1'b1;
      #1;
      checkOutput("wd_buf", iob_read, 36'o111213141516);
      iob_fm_datai = 1'b0; iob_fm_status = 1'b1;

      datao_clear = 1'b1; datao_set = 1'b1; iob_write = 36'o212223242526;
      applyStimulus();
      datao_clear = 1'b0; datao_set = 1'b0; iob_write = '0;
      applyStimulus();
      ch_ready = 1'b0;
      datao_set = 1'b1; iob_write = 36'o000000000001;
      applyStimulus();
      datao_set = 1'b0; iob_write = '0;
      ch_ready = 1'b1;
      repeat (8) applyStimulus();
`ifdef IOB_OVERRUN_ERR_EN
      checkRx("ovr_chars", 6, 48'({6'o21, 6'o22, 6'o23, 6'o24, 6'o25, 6'o26}));
      checkOutput("ovr_status", iob_read, 36'o000000000053);
`else
      checkRx("ovr_chars", 7, 48'({6'o21, 6'o21, 6'o22, 6'o23, 6'o24, 6'o25, 6'o27}));
      checkOutput("ovr_status", iob_read, 36'o000000000013);
`endif

      iob_poweron = 1'b0;
      applyStimulus();
      iob_poweron = 1'b1;
      #1;
      checkOutput("pwr_status", iob_read, 36'd0);
      checkOutput("pwr_pi", 36'(pi_req), 36'd0);
      applyStimulus();

      cmpEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
